// File: rtl/shift_seq_ctrl_if.sv
// Start/operand/result bundle for the sign-magnitude shift sequencer.
// The master drives the operands; the slave (sequencer) returns busy/done/result.
interface shift_seq_ctrl_if #(
  parameter int unsigned N = 8
) ();
  logic         in_start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_out;
  logic         o_ERR;
  logic         o_ovf;

  modport master (
    output in_start, in_a, in_b,
    input  o_busy, o_done, o_out, o_ERR, o_ovf
  );

  modport slave (
    input  in_start, in_a, in_b,
    output o_busy, o_done, o_out, o_ERR, o_ovf
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sign-magnitude left shifter: one magnitude bit per cycle, exact overflow tracking.
// Optional macro SHIFT_CTRL_SAT_EN saturates the magnitude to all ones on overflow.
module shift_seq_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic              clk,
  input  logic              rst,
  shift_seq_ctrl_if.slave   bus
);

  localparam int unsigned MW = N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          sign_q, sign_d;
  logic [MW-1:0] mag_q, mag_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic          ovf_acc_q, ovf_acc_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  out_q, out_d;
  logic          out_err_q, out_err_d;
  logic          out_ovf_q, out_ovf_d;

  // Result outputs are loaded on the edge entering DONE so they are valid alongside o_done.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    err_d     = err_q;
    done_d    = 1'b0;
    out_d     = out_q;
    out_err_d = out_err_q;
    out_ovf_d = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_start) begin
          sign_d    = bus.in_a[N-1];
          mag_d     = bus.in_a[MW-1:0];
          cnt_d     = bus.in_b[MW-1:0];
          ovf_acc_d = 1'b0;
          if (bus.in_b[N-1]) begin
            err_d     = 1'b1;
            state_d   = DONE;
            done_d    = 1'b1;
            out_d     = '0;
            out_err_d = 1'b1;
            out_ovf_d = 1'b0;
          end else begin
            err_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        // A zero magnitude can never overflow further, so stop early.
        if ((cnt_q == '0) || (mag_q == '0)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          out_err_d = err_q;
          out_ovf_d = ovf_acc_q & ~err_q;
`ifdef SHIFT_CTRL_SAT_EN
          out_d     = (ovf_acc_q && !err_q) ? {sign_q, {MW{1'b1}}} : {sign_q, mag_q};
`else
          out_d     = {sign_q, mag_q};
`endif
        end else begin
          ovf_acc_d = ovf_acc_q | mag_q[MW-1];
          mag_d     = {mag_q[MW-2:0], 1'b0};
          cnt_d     = cnt_q - MW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
      out_err_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      out_q     <= out_d;
      out_err_q <= out_err_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_out  = out_q;
  assign bus.o_ERR  = out_err_q;
  assign bus.o_ovf  = out_ovf_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed + random bench for shift_seq_ctrl with an expected-result queue.
module tb_shift_seq_ctrl;

  localparam int unsigned N = 8;

  typedef struct {
    logic [7:0] out;
    logic       err;
    logic       ovf;
    int         lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  shift_seq_ctrl_if #(.N(N)) bus ();

  shift_seq_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: wide shift for result/overflow, lowest set bit for cycle count.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t         e;
    logic [255:0] w;
    int           bm;
    int           lsb;
    int           k;
    if (b[7]) begin
      e.out = 8'h00; e.err = 1'b1; e.ovf = 1'b0; e.lat = 1;
      return e;
    end
    bm  = int'(b[6:0]);
    w   = 256'(a[6:0]) << bm;
    lsb = 7;
    for (int i = 6; i >= 0; i--) if (a[i]) lsb = i;
    k   = (a[6:0] == 7'd0) ? 0 : ((bm < 7 - lsb) ? bm : 7 - lsb);
    e.err = 1'b0;
    e.ovf = |w[255:7];
    e.lat = k + 2;
`ifdef SHIFT_CTRL_SAT_EN
    e.out = e.ovf ? {a[7], 7'h7F} : {a[7], w[6:0]};
`else
    e.out = {a[7], w[6:0]};
`endif
    return e;
  endfunction

  task automatic push_const(input logic [7:0] o, input logic er, input logic ov, input int lat);
    exp_t e;
    e.out = o; e.err = er; e.ovf = ov; e.lat = lat;
    sb.push_back(e);
  endtask

  // Drives one start, waits (bounded) for o_done, pops the expectation and compares.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    int         cyc;
    logic [7:0] prev_out;
    prev_out = bus.o_out;
    @(posedge clk); #1;
    bus.in_start = 1'b1; bus.in_a = a; bus.in_b = b;
    @(posedge clk); #1;
    bus.in_start = 1'b0; bus.in_a = ~a; bus.in_b = 8'h00;
    cyc = 1;
    if (!bus.o_done) begin
      chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
      chk({tag, "_hold"}, 32'(bus.o_out), 32'(prev_out));
    end
    while (!bus.o_done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_out"}, 32'(bus.o_out), 32'(e.out));
    chk({tag, "_err"}, 32'(bus.o_ERR), 32'(e.err));
    chk({tag, "_ovf"}, 32'(bus.o_ovf), 32'(e.ovf));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_keep"}, 32'(bus.o_out), 32'(e.out));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_start = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_out",  32'(bus.o_out),  32'd0);
    chk("rst_err",  32'(bus.o_ERR),  32'd0);
    chk("rst_ovf",  32'(bus.o_ovf),  32'd0);
    rst = 1'b0;

    push_const(8'h0C, 1'b0, 1'b0, 4); run_op("t1", 8'h03, 8'h02);
    push_const(8'h8A, 1'b0, 1'b0, 3); run_op("t2a", 8'h85, 8'h01);
    push_const(8'h00, 1'b0, 1'b0, 2); run_op("t2b", 8'h00, 8'h05);
`ifdef SHIFT_CTRL_SAT_EN
    push_const(8'h7F, 1'b0, 1'b1, 3); run_op("t3", 8'h41, 8'h01);
    push_const(8'h7F, 1'b0, 1'b1, 9); run_op("t4", 8'h01, 8'h7F);
`else
    push_const(8'h02, 1'b0, 1'b1, 3); run_op("t3", 8'h41, 8'h01);
    push_const(8'h00, 1'b0, 1'b1, 9); run_op("t4", 8'h01, 8'h7F);
`endif
    push_const(8'h00, 1'b1, 1'b0, 1); run_op("t5a", 8'h12, 8'h81);
    push_const(8'h02, 1'b0, 1'b0, 3); run_op("t5b", 8'h01, 8'h01);
    push_const(8'h80, 1'b0, 1'b0, 2); run_op("negzero", 8'h80, 8'h03);

    // Abort: start, ignored re-start in cycle 2, reset in cycle 3.
    @(posedge clk); #1;
    bus.in_start = 1'b1; bus.in_a = 8'h01; bus.in_b = 8'h05;
    @(posedge clk); #1;
    bus.in_start = 1'b0;
    @(posedge clk); #1;
    bus.in_start = 1'b1; bus.in_a = 8'h7F; bus.in_b = 8'h85;
    @(posedge clk); #1;
    bus.in_start = 1'b0;
    chk("t6_ignored_err", 32'(bus.o_ERR), 32'd0);
    chk("t6_ignored_busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("t6_rst_out",  32'(bus.o_out),  32'd0);
    chk("t6_rst_err",  32'(bus.o_ERR),  32'd0);
    chk("t6_rst_ovf",  32'(bus.o_ovf),  32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t6_no_done", 32'(bus.o_done), 32'd0);
      @(posedge clk); #1;
    end
    sb.push_back(model(8'h01, 8'h05)); run_op("t6_fresh", 8'h01, 8'h05);

    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      rb = (i % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      sb.push_back(model(ra, rb));
      run_op("rand", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
